// File: rtl/serial_tx_shifter_pkg.sv
// serial_tx_shifter_pkg
// Shared definitions for the serial transmit path: FSM state encodings and
// the idle line level. The matching receiver imports the same package so
// both ends agree on what an idle line looks like.
//
// Optional feature macro: SERIAL_TX_PARITY_EN adds a PARITY state after the
// data bits.
package serial_tx_shifter_pkg;

    // Level driven on tx_out whenever no frame bit is being sent.
    localparam logic IDLE_LEVEL = 1'b1;

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } tx_state_e;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_e;
`endif

endpackage

// File: rtl/serial_tx_shifter_if.sv
// serial_tx_shifter_if
// Load handshake plus serial output of the transmitter.
//   data_in    : parallel word to send (master -> slave)
//   load_valid : data_in valid        (master -> slave)
//   load_ready : new word accepted    (slave -> master)
//   tx_out     : serial line, idles high
//   tx_active  : high while frame bits are on tx_out
//   done       : one-cycle pulse after the last bit of a frame
// slave modport is used by the transmitter, master by whoever feeds it.
interface serial_tx_shifter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             tx_out;
    logic             tx_active;
    logic             done;

    modport master (
        output data_in, load_valid,
        input  load_ready, tx_out, tx_active, done
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, tx_out, tx_active, done
    );
endinterface

// File: rtl/serial_tx_shifter_tx_bit_counter.sv
// serial_tx_shifter_tx_bit_counter
// Bit counter for the transmitter: CNT_W-bit synchronous up-counter with a
// clear and a terminal-count flag that is high when the count equals
// WIDTH-1 (the last data bit of a frame).
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, count -> 0
//   clr   : synchronous clear (start of frame)
//   inc   : advance by one
//   tc    : count == WIDTH-1
module serial_tx_shifter_tx_bit_counter #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = (cnt_q == CNT_W'(WIDTH - 1));

    // Returning to zero on the terminal count keeps the counter from running
    // past WIDTH-1 for widths that are not a power of two.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx_shifter.sv
// serial_tx_shifter
// Parallel-to-serial transmitter. A WIDTH-bit word accepted over the
// load_valid/load_ready handshake is shifted out LSB-first on tx_out, one
// bit per clock, starting the cycle after the accepting edge. done pulses
// in the first idle cycle after the frame; a load may be accepted in that
// same cycle, so back-to-back frames are separated by exactly one cycle.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset; aborts any frame, no done pulse
//   bus   : serial_tx_shifter_if.slave (data_in, load_valid, load_ready,
//           tx_out, tx_active, done)
//
// Optional feature macro: SERIAL_TX_PARITY_EN. When defined, one extra
// cycle after the data bits carries the even-parity bit of the latched
// word and the frame becomes WIDTH+1 cycles.
module serial_tx_shifter
    import serial_tx_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 reset,
    serial_tx_shifter_if.slave  bus
);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             done_q, done_d;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_tc;
    logic             tx_bit;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    serial_tx_shifter_tx_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    shift_d = bus.data_in;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = 1'b0;
`endif
                end
            end
            SHIFT: begin
                shift_d = {1'b0, shift_q[WIDTH-1:1]};
                cnt_inc = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                // Parity accumulates from the bits actually sent, i.e. the
                // latched word, never from the live data_in.
                parity_d = parity_q ^ shift_q[0];
                if (cnt_tc) begin
                    state_d = PARITY;
                end
`else
                if (cnt_tc) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
`endif
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        tx_bit = IDLE_LEVEL;
        case (state_q)
            SHIFT:   tx_bit = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  tx_bit = parity_q;
`endif
            default: tx_bit = IDLE_LEVEL;
        endcase
    end

    assign bus.tx_out     = tx_bit;
    assign bus.load_ready = (state_q == IDLE);
    assign bus.tx_active  = (state_q != IDLE);
    assign bus.done       = done_q;

endmodule
